game_status_regs: RTL and testbench
===================================

# game_status_regs

Register bank on the receiving end of the game FSM's load interface: holds score, fruit-eaten mask and lives-lost count, and feeds them back to the FSM as `*_from_reg`. It also converts the score to four BCD digits for the HUD with a multi-cycle double-dabble engine. It runs the post-death respawn freeze timer and latches the win/lose outcome until the next restart. It sits between the game FSM, the HUD/sprite renderer and the frame-tick generator.

## Interface
Parameters:
- FREEZE_FRAMES, 60, number of frame ticks `freeze` stays high after a life is lost (1..255)
- MAX_LIVES, 3, lives per game; the lives-lost count saturates here

Ports:
- Clk  in  1  system clock
- Reset  in  1  reset, synchronous, active-high
- Load_S  in  1  write `score_to_reg` into the score register
- Load_F  in  1  write `fruits_to_reg` into the fruit mask
- Load_L  in  1  write `lives_to_reg` into the lives-lost count
- score_to_reg  in  10  new score
- fruits_to_reg  in  4  new fruit mask; bit set = fruit eaten
- lives_to_reg  in  8  new lives-lost count
- restart  in  1  level from FSM; clears all game state
- lifeDown  in  1  FSM life-lost indication; starts the freeze timer
- win, lose  in  1  FSM outcome indications
- frame_tick  in  1  one-cycle pulse per video frame
- score_from_reg  out  10  stored score
- fruits_from_reg  out  4  stored fruit mask
- lives_from_reg  out  2  stored lives-lost count
- lives_left  out  2  MAX_LIVES − lives_from_reg
- bcd_digits  out  16  score in BCD: [15:12] thousands … [3:0] ones
- bcd_valid  out  1  bcd_digits matches score_from_reg
- freeze  out  1  respawn hold; movement is gated while high
- game_over_latched, game_won_latched  out  1  sticky outcome flags

## Operation
- Priority on every edge: Reset > restart > loads/events.
- Reset or restart clears:
  - score, fruits and lives to 0
  - bcd_digits to 0 with bcd_valid=1; any in-flight conversion is aborted
  - the freeze counter to 0
  - both latched outcome flags
- Load_S: score ← score_to_reg, updated at the sampling edge. Load_F and Load_L behave the same way for their registers.
- Load_L: lives ← min(lives_to_reg, MAX_LIVES) on the 8-bit value, truncated to 2 bits.
- Simultaneous Load_S/F/L are independent; all three apply.
- BCD engine states:
  - IDLE: bcd_valid=1.
  - SHIFT: 10 iterations. Each iteration adds 3 to every BCD nibble ≥5, then shifts the 26-bit {bcd, bin} register left by 1.
  - On completion: writes bcd_digits atomically, sets bcd_valid, returns to IDLE.
- BCD triggers and aborts:
  - A Load_S edge (re)starts SHIFT from the new score, including during SHIFT: the current conversion is aborted, no partial digits are ever shown, and bcd_digits holds its last complete value.
  - A Load_S with an unchanged value still triggers a conversion.
- Freeze timer:
  - lifeDown sampled high loads the counter with FREEZE_FRAMES, including while the counter is already nonzero.
  - frame_tick decrements the counter when it is nonzero.
  - freeze = (counter ≠ 0).
  - lifeDown and frame_tick in the same cycle: the load wins.
- Outcome flags: lose sets game_over_latched; win sets game_won_latched. If win and lose are high in the same cycle, only game_over_latched sets. Once either flag is set, the other cannot set until cleared. Setting game_over_latched clears the freeze counter.

## Timing
- All outputs are registered except lives_left, which is combinational from lives_from_reg.
- Register update latency: 1 cycle. A load sampled at edge E is visible after E.
- BCD latency: Load_S at edge E deasserts bcd_valid after E. Digits update and bcd_valid reasserts after edge E+10. bcd_valid stays low through edges E+1..E+9.
- Freeze: lifeDown at edge E raises freeze after E. freeze falls after the FREEZE_FRAMES-th subsequent frame_tick edge.
- Reset/restart values take effect after the sampling edge. A restart held over several cycles keeps everything cleared.
- Reset values: score/fruits/lives 0, lives_left=MAX_LIVES, bcd_digits=16'h0000, bcd_valid=1, freeze=0, both latched flags 0.

## Test plan
- Reset, then Load_S=1 with score_to_reg=1023 → bcd_valid low for 10 cycles, then bcd_digits=16'h1023 and bcd_valid=1; score_from_reg=1023 one cycle after the load.
- Load_S=50, then at the 4th cycle of SHIFT Load_S=100 → bcd_digits stays 16'h0000 until 10 cycles after the second load, then 16'h0100; 16'h0050 never appears.
- Load_L with lives_to_reg=8'd7 → lives_from_reg=3, lives_left=0. Load_L with 8'd1 → lives_left=2.
- FREEZE_FRAMES=3: lifeDown, then frame_tick on 2 edges, lifeDown again, then 3 frame_ticks → freeze stays high until the 5th tick overall; lifeDown and frame_tick together leave the counter at 3.
- win and lose in the same cycle → game_over_latched=1, game_won_latched=0, freeze=0. A later win pulse → no change. restart → both flags 0, all registers 0, bcd_digits=0 with bcd_valid=1.
- Load_S, Load_F and restart in the same cycle → restart wins: score=0, fruits=0, no conversion started, bcd_valid stays 1.

Source files
------------

// File: rtl/game_status_regs.sv
// Game status register bank: score, fruit mask and lives-lost count with
// BCD score conversion for the HUD, respawn freeze timer and sticky outcome.
// Ports:
//   Clk, Reset (sync, active-high), restart (level, clears all game state)
//   Load_S/F/L with score_to_reg/fruits_to_reg/lives_to_reg  : register writes
//   lifeDown, frame_tick : freeze timer control
//   win, lose            : outcome events
//   score/fruits/lives_from_reg, lives_left, bcd_digits, bcd_valid,
//   freeze, game_over_latched, game_won_latched
module game_status_regs #(
  parameter int FREEZE_FRAMES = 60,
  parameter int MAX_LIVES     = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load_S,
  input  logic        Load_F,
  input  logic        Load_L,
  input  logic [9:0]  score_to_reg,
  input  logic [3:0]  fruits_to_reg,
  input  logic [7:0]  lives_to_reg,
  input  logic        restart,
  input  logic        lifeDown,
  input  logic        win,
  input  logic        lose,
  input  logic        frame_tick,
  output logic [9:0]  score_from_reg,
  output logic [3:0]  fruits_from_reg,
  output logic [1:0]  lives_from_reg,
  output logic [1:0]  lives_left,
  output logic [15:0] bcd_digits,
  output logic        bcd_valid,
  output logic        freeze,
  output logic        game_over_latched,
  output logic        game_won_latched
);

  localparam logic [7:0] MAX8 = 8'(MAX_LIVES);
  localparam logic [1:0] MAX2 = 2'(MAX_LIVES);
  localparam logic [7:0] FRZ  = 8'(FREEZE_FRAMES);

  typedef enum logic {IDLE, SHIFT} bcd_state_t;

  logic        clr;
  bcd_state_t  st, st_n;
  logic [25:0] sh, sh_n, sh_step;
  logic [3:0]  it, it_n;
  logic [15:0] bcd_n;
  logic        valid_n;
  logic [7:0]  frz;
  logic        set_over, set_won;

  assign clr = Reset | restart;

  // One double-dabble iteration: adjust BCD nibbles, then shift.
  function automatic logic [25:0] dd(input logic [25:0] v);
    logic [25:0] t;
    t = v;
    for (int k = 0; k < 4; k++) begin
      if (t[10+4*k +: 4] >= 4'd5)
        t[10+4*k +: 4] = t[10+4*k +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  assign sh_step = dd(sh);

  always_comb begin
    st_n    = st;
    sh_n    = sh;
    it_n    = it;
    bcd_n   = bcd_digits;
    valid_n = bcd_valid;
    if (clr) begin
      st_n    = IDLE;
      sh_n    = '0;
      it_n    = '0;
      bcd_n   = '0;
      valid_n = 1'b1;
    end else if (Load_S) begin
      // A new score always restarts; the old digits stay on screen.
      st_n    = SHIFT;
      sh_n    = {16'h0000, score_to_reg};
      it_n    = '0;
      valid_n = 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          valid_n = 1'b1;
        end
        SHIFT: begin
          sh_n = sh_step;
          it_n = it + 4'd1;
          if (it == 4'd9) begin
            st_n    = IDLE;
            bcd_n   = sh_step[25:10];
            valid_n = 1'b1;
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    st         <= st_n;
    sh         <= sh_n;
    it         <= it_n;
    bcd_digits <= bcd_n;
    bcd_valid  <= valid_n;
  end

  always_ff @(posedge Clk) begin
    if (clr) begin
      score_from_reg  <= '0;
      fruits_from_reg <= '0;
      lives_from_reg  <= '0;
    end else begin
      if (Load_S) score_from_reg <= score_to_reg;
      if (Load_F) fruits_from_reg <= fruits_to_reg;
      if (Load_L)
        lives_from_reg <= (lives_to_reg > MAX8) ? MAX2 : lives_to_reg[1:0];
    end
  end

  assign lives_left = MAX2 - lives_from_reg;

  // Lose beats a simultaneous win; whichever flag sets first locks out the other.
  assign set_over = lose & ~game_over_latched & ~game_won_latched;
  assign set_won  = win & ~lose & ~game_over_latched & ~game_won_latched;

  always_ff @(posedge Clk) begin
    if (clr) begin
      game_over_latched <= 1'b0;
      game_won_latched  <= 1'b0;
      frz               <= '0;
    end else begin
      if (set_over) game_over_latched <= 1'b1;
      if (set_won) game_won_latched <= 1'b1;
      if (set_over) frz <= '0;
      else if (lifeDown) frz <= FRZ;
      else if (frame_tick && frz != 8'd0) frz <= frz - 8'd1;
    end
  end

  assign freeze = (frz != 8'd0);

endmodule

// File: tb/tb_game_status_regs.sv
// Self-checking bench for game_status_regs: directed table, corner
// sequences, and random stimulus against an arithmetic reference model.
module tb_game_status_regs;

  localparam int FF = 3;
  localparam int ML = 3;

  logic        Clk = 1'b0;
  logic        Reset, Load_S, Load_F, Load_L, restart;
  logic        lifeDown, win, lose, frame_tick;
  logic [9:0]  score_to_reg;
  logic [3:0]  fruits_to_reg;
  logic [7:0]  lives_to_reg;
  logic [9:0]  score_from_reg;
  logic [3:0]  fruits_from_reg;
  logic [1:0]  lives_from_reg, lives_left;
  logic [15:0] bcd_digits;
  logic        bcd_valid, freeze, game_over_latched, game_won_latched;

  game_status_regs #(.FREEZE_FRAMES(FF), .MAX_LIVES(ML)) dut (
    .Clk(Clk), .Reset(Reset), .Load_S(Load_S), .Load_F(Load_F),
    .Load_L(Load_L), .score_to_reg(score_to_reg),
    .fruits_to_reg(fruits_to_reg), .lives_to_reg(lives_to_reg),
    .restart(restart), .lifeDown(lifeDown), .win(win), .lose(lose),
    .frame_tick(frame_tick), .score_from_reg(score_from_reg),
    .fruits_from_reg(fruits_from_reg), .lives_from_reg(lives_from_reg),
    .lives_left(lives_left), .bcd_digits(bcd_digits),
    .bcd_valid(bcd_valid), .freeze(freeze),
    .game_over_latched(game_over_latched),
    .game_won_latched(game_won_latched)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic rst, rs, ls, lf, ll;
    logic [9:0] sc;
    logic [3:0] fr;
    logic [7:0] lv;
    logic ld, w, l, t;
  } in_t;

  typedef struct packed {
    in_t i;
    logic [9:0] e_score;
    logic [1:0] e_left;
    logic [15:0] e_bcd;
    logic e_valid, e_frz, e_over, e_won;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_score, m_fruits, m_lives, m_frz, m_cd, m_pend;
  int m_bcd;
  bit m_valid, m_over, m_won;

  function automatic int to_bcd(input int s);
    return ((s / 1000) << 12) | (((s / 100) % 10) << 8) |
           (((s / 10) % 10) << 4) | (s % 10);
  endfunction

  function automatic in_t idle();
    in_t x;
    x = '0;
    return x;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic model(input in_t x);
    bit so, sw;
    if (x.rst || x.rs) begin
      m_score = 0; m_fruits = 0; m_lives = 0; m_frz = 0;
      m_cd = 0; m_bcd = 0; m_valid = 1; m_over = 0; m_won = 0;
      return;
    end
    if (x.ls) begin
      m_pend = int'(x.sc); m_cd = 10; m_valid = 0;
    end else if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) begin
        m_bcd = to_bcd(m_pend); m_valid = 1;
      end
    end
    if (x.ls) m_score = int'(x.sc);
    if (x.lf) m_fruits = int'(x.fr);
    if (x.ll) m_lives = (int'(x.lv) > ML) ? ML : int'(x.lv);
    so = x.l && !m_over && !m_won;
    sw = x.w && !x.l && !m_over && !m_won;
    if (so) m_over = 1;
    if (sw) m_won = 1;
    if (so) m_frz = 0;
    else if (x.ld) m_frz = FF;
    else if (x.t && m_frz > 0) m_frz--;
  endtask

  task automatic check_model();
    chk("score", int'(score_from_reg), m_score);
    chk("fruits", int'(fruits_from_reg), m_fruits);
    chk("lives", int'(lives_from_reg), m_lives);
    chk("lives_left", int'(lives_left), ML - m_lives);
    chk("bcd", int'(bcd_digits), m_bcd);
    chk("bcd_valid", int'(bcd_valid), int'(m_valid));
    chk("freeze", int'(freeze), int'(m_frz != 0));
    chk("over", int'(game_over_latched), int'(m_over));
    chk("won", int'(game_won_latched), int'(m_won));
  endtask

  task automatic step(input in_t x);
    Reset = x.rst; restart = x.rs; Load_S = x.ls; Load_F = x.lf;
    Load_L = x.ll; score_to_reg = x.sc; fruits_to_reg = x.fr;
    lives_to_reg = x.lv; lifeDown = x.ld; win = x.w; lose = x.l;
    frame_tick = x.t;
    @(posedge Clk);
    model(x);
    #1;
    check_model();
  endtask

  function automatic vec_t mk(input in_t x, input int sc, input int lf,
                              input int bcd, input bit v, input bit fz);
    vec_t r;
    r.i = x; r.e_score = 10'(sc); r.e_left = 2'(lf);
    r.e_bcd = 16'(bcd); r.e_valid = v; r.e_frz = fz;
    r.e_over = 1'b0; r.e_won = 1'b0;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    in_t x;
    Reset = 1; restart = 0; Load_S = 0; Load_F = 0; Load_L = 0;
    score_to_reg = 0; fruits_to_reg = 0; lives_to_reg = 0;
    lifeDown = 0; win = 0; lose = 0; frame_tick = 0;

    // Directed table
    x = idle(); x.rst = 1;
    tbl.push_back(mk(x, 0, 3, 16'h0000, 1, 0));
    x = idle(); x.ls = 1; x.sc = 10'd1023;
    tbl.push_back(mk(x, 1023, 3, 16'h0000, 0, 0));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(idle(), 1023, 3, 16'h0000, 0, 0));
    tbl.push_back(mk(idle(), 1023, 3, 16'h1023, 1, 0));
    x = idle(); x.ll = 1; x.lv = 8'd7;
    tbl.push_back(mk(x, 1023, 0, 16'h1023, 1, 0));
    x = idle(); x.ll = 1; x.lv = 8'd1;
    tbl.push_back(mk(x, 1023, 2, 16'h1023, 1, 0));
    x = idle(); x.ld = 1;
    tbl.push_back(mk(x, 1023, 2, 16'h1023, 1, 1));

    foreach (tbl[k]) begin
      step(tbl[k].i);
      chk("tbl_score", int'(score_from_reg), int'(tbl[k].e_score));
      chk("tbl_left", int'(lives_left), int'(tbl[k].e_left));
      chk("tbl_bcd", int'(bcd_digits), int'(tbl[k].e_bcd));
      chk("tbl_valid", int'(bcd_valid), int'(tbl[k].e_valid));
      chk("tbl_freeze", int'(freeze), int'(tbl[k].e_frz));
      chk("tbl_over", int'(game_over_latched), int'(tbl[k].e_over));
      chk("tbl_won", int'(game_won_latched), int'(tbl[k].e_won));
    end

    // Abort: Load_S 50 then Load_S 100 during SHIFT
    x = idle(); x.rst = 1; step(x);
    x = idle(); x.ls = 1; x.sc = 10'd50; step(x);
    for (int k = 0; k < 3; k++) begin
      step(idle());
      chk("abort_hold", int'(bcd_digits), 16'h0000);
    end
    x = idle(); x.ls = 1; x.sc = 10'd100; step(x);
    for (int k = 1; k <= 10; k++) begin
      step(idle());
      if (bcd_digits == 16'h0050) chk("abort_no50", int'(bcd_digits), 0);
      chk("abort_valid", int'(bcd_valid), int'(k == 10));
      chk("abort_bcd", int'(bcd_digits), (k == 10) ? 16'h0100 : 16'h0000);
    end

    // Freeze: lifeDown, 2 ticks, lifeDown, 3 ticks
    x = idle(); x.ld = 1; step(x);
    x = idle(); x.t = 1;
    step(x); step(x);
    chk("frz_2ticks", int'(freeze), 1);
    x = idle(); x.ld = 1; step(x);
    x = idle(); x.t = 1;
    step(x); step(x);
    chk("frz_4ticks", int'(freeze), 1);
    step(x);
    chk("frz_5ticks", int'(freeze), 0);
    // lifeDown together with frame_tick: load wins
    x = idle(); x.ld = 1; x.t = 1; step(x);
    x = idle(); x.t = 1;
    step(x); step(x);
    chk("frz_both_2", int'(freeze), 1);
    step(x);
    chk("frz_both_3", int'(freeze), 0);

    // Outcome: freeze active, then win+lose together
    x = idle(); x.ld = 1; step(x);
    x = idle(); x.w = 1; x.l = 1; step(x);
    chk("out_over", int'(game_over_latched), 1);
    chk("out_won", int'(game_won_latched), 0);
    chk("out_frz", int'(freeze), 0);
    x = idle(); x.w = 1; step(x);
    chk("out_win_late", int'(game_won_latched), 0);
    x = idle(); x.lf = 1; x.fr = 4'hA; x.ll = 1; x.lv = 8'd2; step(x);
    x = idle(); x.rs = 1; step(x);
    step(x);
    chk("rs_over", int'(game_over_latched), 0);
    chk("rs_score", int'(score_from_reg), 0);
    chk("rs_fruits", int'(fruits_from_reg), 0);
    chk("rs_bcd", int'(bcd_digits), 0);
    chk("rs_valid", int'(bcd_valid), 1);
    // win alone, then lose blocked
    x = idle(); x.w = 1; step(x);
    x = idle(); x.l = 1; step(x);
    chk("won_only", int'(game_won_latched), 1);
    chk("lose_blocked", int'(game_over_latched), 0);

    // Loads with restart: restart wins
    x = idle(); x.rs = 1; x.ls = 1; x.lf = 1; x.sc = 10'd77; x.fr = 4'h5;
    step(x);
    chk("rsld_score", int'(score_from_reg), 0);
    chk("rsld_fruits", int'(fruits_from_reg), 0);
    step(idle());
    chk("rsld_valid", int'(bcd_valid), 1);

    // Random stimulus against the model
    for (int n = 0; n < 600; n++) begin
      x = idle();
      x.rst = ($urandom_range(0, 99) == 0);
      x.rs  = ($urandom_range(0, 49) == 0);
      x.ls  = ($urandom_range(0, 9) == 0);
      x.lf  = ($urandom_range(0, 3) == 0);
      x.ll  = ($urandom_range(0, 3) == 0);
      x.sc  = 10'($urandom_range(0, 1023));
      x.fr  = 4'($urandom);
      x.lv  = 8'($urandom);
      x.ld  = ($urandom_range(0, 19) == 0);
      x.w   = ($urandom_range(0, 29) == 0);
      x.l   = ($urandom_range(0, 29) == 0);
      x.t   = ($urandom_range(0, 2) == 0);
      step(x);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
